// File: rtl/keypad_pkg.sv
// Shared types and the key map for the 4x4 keypad scanner.
// Patterns are active-low: a single 0 marks the driven column or the pressed row.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  // Indexed by {row, col}; entry 0 is the rightmost nibble.
  localparam logic [15:0][3:0] KEY_MAP = {
    4'hD, 4'hF, 4'h0, 4'hE,
    4'hC, 4'h9, 4'h8, 4'h7,
    4'hB, 4'h6, 4'h5, 4'h4,
    4'hA, 4'h3, 4'h2, 4'h1
  };

  function automatic logic single_low(input logic [3:0] v);
    return (v == 4'b1110) || (v == 4'b1101) || (v == 4'b1011) || (v == 4'b0111);
  endfunction

  function automatic logic [1:0] low_index(input logic [3:0] v);
    case (v)
      4'b1101: return 2'd1;
      4'b1011: return 2'd2;
      4'b0111: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  function automatic logic [3:0] low_pattern(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/scan_tick.sv
// Free-running divider: one-cycle tick every SCAN_CYCLES+1 clocks.
module scan_tick #(
  parameter logic [23:0] SCAN_CYCLES = 24'd49999
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  logic [23:0] count;

  assign tick = (count == SCAN_CYCLES);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= 24'd0;
    end else if (tick) begin
      count <= 24'd0;
    end else begin
      count <= count + 24'd1;
    end
  end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner: rotates an active-low column strobe, debounces press and
// release over DEBOUNCE_TICKS scan ticks, and reports the accepted key as a hex code.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter logic [23:0] SCAN_CYCLES    = 24'd49999,
  parameter logic [7:0]  DEBOUNCE_TICKS = 8'd20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  logic       tick;
  logic [3:0] rows_meta;
  logic [3:0] rs;

  state_t     state, state_n;
  logic [1:0] col_idx, col_idx_n;
  logic [1:0] row_idx, row_idx_n;
  logic [7:0] dcnt, dcnt_n;
  logic [7:0] dcnt_inc;
  logic       accept;

  scan_tick #(
    .SCAN_CYCLES(SCAN_CYCLES)
  ) u_scan_tick (
    .clk  (clk),
    .reset(reset),
    .tick (tick)
  );

  // rows come straight from the keypad, so double-flop them before use.
  always_ff @(posedge clk) begin
    if (reset) begin
      rows_meta <= 4'b1111;
      rs        <= 4'b1111;
    end else begin
      rows_meta <= rows;
      rs        <= rows_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= SCAN;
      col_idx   <= 2'd0;
      row_idx   <= 2'd0;
      dcnt      <= 8'd0;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
    end else begin
      state     <= state_n;
      col_idx   <= col_idx_n;
      row_idx   <= row_idx_n;
      dcnt      <= dcnt_n;
      key_valid <= accept;
      if (accept) begin
        key_code <= KEY_MAP[{row_idx, col_idx}];
      end
    end
  end

  assign dcnt_inc = (dcnt == 8'hFF) ? dcnt : dcnt + 8'd1;

  always_comb begin
    state_n   = state;
    col_idx_n = col_idx;
    row_idx_n = row_idx;
    dcnt_n    = dcnt;
    accept    = 1'b0;
    if (tick) begin
      case (state)
        SCAN: begin
          if (single_low(rs)) begin
            row_idx_n = low_index(rs);
            dcnt_n    = 8'd0;
            state_n   = DEBOUNCE;
          end else begin
            col_idx_n = col_idx + 2'd1;
          end
        end
        DEBOUNCE: begin
          if (rs == low_pattern(row_idx)) begin
            dcnt_n = dcnt_inc;
            if (dcnt_inc == DEBOUNCE_TICKS) begin
              state_n = HELD;
              accept  = 1'b1;
            end
          end else begin
            state_n   = SCAN;
            col_idx_n = col_idx + 2'd1;
          end
        end
        HELD: begin
          if (rs == 4'b1111) begin
            dcnt_n  = 8'd0;
            state_n = RELEASE;
          end
        end
        RELEASE: begin
          if (rs == 4'b1111) begin
            dcnt_n = dcnt_inc;
            if (dcnt_inc == DEBOUNCE_TICKS) begin
              state_n   = SCAN;
              col_idx_n = col_idx + 2'd1;
            end
          end else begin
            state_n = HELD;
          end
        end
        default: state_n = SCAN;
      endcase
    end
  end

  always_comb begin
    cols     = low_pattern(col_idx);
    key_held = (state == HELD) || (state == RELEASE);
  end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench with a behavioural keypad; key_valid pulses are scored against a queue.
module tb_keypad_scan_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] rows;
  logic [3:0] cols;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  logic       key_down = 1'b0;
  logic [3:0] key_pat  = 4'b1111;
  logic [1:0] key_col  = 2'd0;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [3:0] exp_q[$];

  always #5 clk = ~clk;

  // A pressed key only pulls its row(s) low while its own column is driven.
  assign rows = (key_down && !cols[key_col]) ? key_pat : 4'b1111;

  keypad_scan_ctrl #(
    .SCAN_CYCLES   (24'd3),
    .DEBOUNCE_TICKS(8'd3)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rows     (rows),
    .cols     (cols),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (key_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected key_valid: key_code %h, no pulse expected", key_code);
      end else begin
        check("pulse key_code", key_code, exp_q.pop_front());
        check("pulse key_held", {3'b000, key_held}, 4'h1);
      end
    end
  end

  // Bench stays aligned to just after the DUT's acting edge: 4 clocks per tick.
  task automatic tick();
    repeat (4) @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] col_drive(input int c);
    case (c)
      0:       return 4'b1110;
      1:       return 4'b1101;
      2:       return 4'b1011;
      default: return 4'b0111;
    endcase
  endfunction

  initial begin
    int ecol;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset cols", cols, 4'b1110);
    check("reset key_code", key_code, 4'h0);
    check("reset key_valid", {3'b000, key_valid}, 4'h0);
    check("reset key_held", {3'b000, key_held}, 4'h0);
    reset = 1'b0;
    ecol = 0;

    // Idle scan rotation
    for (int i = 1; i <= 4; i++) begin
      tick();
      ecol = i % 4;
      check("idle cols", cols, col_drive(ecol));
    end

    // Key (r1,c2) -> 6
    key_pat = 4'b1101; key_col = 2'd2; key_down = 1'b1;
    tick(); check("scan to c1", cols, 4'b1101);
    tick(); check("scan to c2", cols, 4'b1011);
    tick(); tick(); tick();
    check("no early held", {3'b000, key_held}, 4'h0);
    exp_q.push_back(4'h6);
    tick();
    check("held after accept", {3'b000, key_held}, 4'h1);
    check("cols frozen", cols, 4'b1011);
    check("key_code 6", key_code, 4'h6);
    tick(); tick();
    check("still held", {3'b000, key_held}, 4'h1);
    check("cols frozen hold", cols, 4'b1011);

    // One-tick release glitch
    key_down = 1'b0;
    tick(); check("glitch held a", {3'b000, key_held}, 4'h1);
    key_down = 1'b1;
    tick(); check("glitch held b", {3'b000, key_held}, 4'h1);

    // Full release
    key_down = 1'b0;
    tick(); tick(); tick();
    check("release not early", {3'b000, key_held}, 4'h1);
    tick();
    check("released", {3'b000, key_held}, 4'h0);
    check("cols after release", cols, 4'b0111);

    // Key (r0,c3) -> A, bounces out of debounce once
    key_pat = 4'b1110; key_col = 2'd3; key_down = 1'b1;
    tick();
    key_down = 1'b0;
    tick(); check("bounce back to scan", cols, 4'b1110);
    key_down = 1'b1;
    tick(); tick(); tick();
    check("rescan to c3", cols, 4'b0111);
    tick(); tick(); tick();
    check("bounce no early held", {3'b000, key_held}, 4'h0);
    exp_q.push_back(4'hA);
    tick();
    check("bounce held", {3'b000, key_held}, 4'h1);
    check("key_code A", key_code, 4'hA);
    key_down = 1'b0;
    tick(); tick(); tick(); tick();
    check("A released", {3'b000, key_held}, 4'h0);
    check("cols after A", cols, 4'b1110);

    // Two rows low is ignored
    ecol = 0;
    key_pat = 4'b1100; key_col = 2'd0; key_down = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      ecol = (ecol + 1) % 4;
      check("multi-row cols", cols, col_drive(ecol));
    end
    check("multi-row held", {3'b000, key_held}, 4'h0);
    key_down = 1'b0;

    // Key (r3,c2) -> F; reset at debounce count 2, then re-debounced
    key_pat = 4'b0111; key_col = 2'd2; key_down = 1'b1;
    tick(); tick();
    check("reach c2", cols, 4'b1011);
    tick(); tick(); tick();
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("mid reset cols", cols, 4'b1110);
    check("mid reset key_code", key_code, 4'h0);
    check("mid reset key_valid", {3'b000, key_valid}, 4'h0);
    check("mid reset key_held", {3'b000, key_held}, 4'h0);
    reset = 1'b0;
    tick(); tick();
    check("post reset c2", cols, 4'b1011);
    tick(); tick(); tick();
    check("post reset no held", {3'b000, key_held}, 4'h0);
    exp_q.push_back(4'hF);
    tick();
    check("key_code F", key_code, 4'hF);
    check("F held", {3'b000, key_held}, 4'h1);
    key_down = 1'b0;
    tick(); tick(); tick(); tick();
    check("F released", {3'b000, key_held}, 4'h0);

    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL missing pulses: %0d outstanding, expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
